// File: rtl/lap_stopwatch.sv
// MM:SS:CC BCD stopwatch/timer with up/down count, preset load and a small lap buffer.
// Single-cycle command pulses from the button front end drive a four-state controller.
module lap_stopwatch #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned TICK_HZ     = 100,
    parameter int unsigned LAP_DEPTH   = 4,
    localparam int unsigned IW         = (LAP_DEPTH > 2) ? $clog2(LAP_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 lap_i,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic                 mode_i,
    input  logic [23:0]          preset_bcd_i,
    input  logic [IW-1:0]        rd_idx_i,
    output logic [23:0]          bcd_o,
    output logic [23:0]          rd_bcd_o,
    output logic [IW:0]          lap_count_o,
    output logic [LAP_DEPTH-1:0] led_o,
    output logic                 running_o,
    output logic                 expired_o
);
    localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned CW  = IW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUNNING = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    logic [1:0]           state, state_d;
    logic [23:0]          count, count_d;
    logic [CW-1:0]        lap_count, lap_count_d;
    logic                 mode, mode_d;
    logic [DW-1:0]        div_cnt, div_d;
    logic                 tick;
    logic                 lap_we;
    logic [23:0]          step_val;
    logic [LAP_DEPTH-1:0] led_d;
    logic [23:0]          lap_buf [LAP_DEPTH];

    // Digit index 0 is cs ones; tens of seconds and minutes roll at 5.
    function automatic logic [3:0] digit_max(input int i);
        return (i == 3 || i == 5) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic bcd_valid(input logic [23:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (v[i*4 +: 4] > digit_max(i)) ok = 1'b0;
        end
        return ok;
    endfunction

    // One-centisecond BCD increment or decrement with ripple carry/borrow.
    function automatic logic [23:0] bcd_step(input logic [23:0] v, input logic down);
        logic [23:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (c) begin
                if (!down) begin
                    if (v[i*4 +: 4] >= digit_max(i)) r[i*4 +: 4] = 4'd0;
                    else begin
                        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (v[i*4 +: 4] == 4'd0) r[i*4 +: 4] = digit_max(i);
                    else begin
                        r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Next-state and datapath decode; clear > stop > lap > start > load.
    always_comb begin
        state_d     = state;
        count_d     = count;
        lap_count_d = lap_count;
        mode_d      = mode;
        lap_we      = 1'b0;
        led_d       = '0;
        tick        = (state == S_RUNNING) && (div_cnt == DW'(DIV - 1));
        step_val    = bcd_step(count, mode);
        div_d       = '0;
        if (state == S_RUNNING && !tick) div_d = div_cnt + DW'(1);

        if (clear_i) begin
            state_d     = S_IDLE;
            count_d     = '0;
            lap_count_d = '0;
            mode_d      = 1'b0;
            div_d       = '0;
        end else if (stop_i && state == S_RUNNING) begin
            state_d = S_PAUSED;
            div_d   = '0;
        end else begin
            if (lap_i && (state == S_RUNNING || state == S_PAUSED)) begin
                if (lap_count < CW'(LAP_DEPTH)) begin
                    lap_we      = 1'b1;
                    lap_count_d = lap_count + CW'(1);
                end
            end else if (start_i && state == S_IDLE) begin
                if (!(mode_i && count == 24'd0)) begin
                    state_d = S_RUNNING;
                    mode_d  = mode_i;
                end
            end else if (start_i && state == S_PAUSED) begin
                state_d = S_RUNNING;
            end else if (load_i && state == S_IDLE && bcd_valid(preset_bcd_i)) begin
                count_d = preset_bcd_i;
            end

            if (tick) begin
                count_d = step_val;
                if (mode && step_val == 24'd0) state_d = S_EXPIRED;
            end
        end

        for (int k = 0; k < LAP_DEPTH; k++) begin
            led_d[k] = (lap_count_d > CW'(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            count     <= '0;
            lap_count <= '0;
            mode      <= 1'b0;
            div_cnt   <= '0;
            led_o     <= '0;
            running_o <= 1'b0;
            expired_o <= 1'b0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            lap_count <= lap_count_d;
            mode      <= mode_d;
            div_cnt   <= div_d;
            led_o     <= led_d;
            running_o <= (state_d == S_RUNNING);
            expired_o <= (state_d == S_EXPIRED);
        end
    end

    // Lap storage and registered readback; entries beyond lap_count read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAP_DEPTH; i++) lap_buf[i] <= '0;
            rd_bcd_o <= '0;
        end else begin
            if (lap_we) lap_buf[lap_count[IW-1:0]] <= count;
            rd_bcd_o <= ({1'b0, rd_idx_i} < lap_count) ? lap_buf[rd_idx_i] : '0;
        end
    end

    assign bcd_o       = count;
    assign lap_count_o = lap_count;

endmodule
